// File: rtl/uart_pkg.sv
// Shared UART types and helpers used by the TX stream block and the planned RX.
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE,
        PAR_ODD,
        PAR_EVEN
    } parity_e;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_e;

    function automatic int unsigned bit_cycles(input int unsigned clk_freq,
                                               input int unsigned baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read data (updated on the pop edge) and an
// occupancy count; DEPTH is a power of two so the pointers wrap naturally.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           push,
    input  logic                           pop,
    input  logic [WIDTH-1:0]               wdata,
    output logic [WIDTH-1:0]               rdata,
    output logic                           full,
    output logic                           empty,
    output logic [$clog2(DEPTH+1)-1:0]     level
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic             do_push, do_pop;

    assign full  = (level_q == LVL_W'(DEPTH));
    assign empty = (level_q == '0);
    assign level = level_q;
    assign rdata = rdata_q;

    always_comb begin
        do_push  = push && !full;
        do_pop   = pop && !empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        rdata_d  = rdata_q;
        level_d  = level_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            rdata_d  = mem_q[rd_ptr_q];
        end
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            rdata_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            rdata_q  <= rdata_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/uart_tx_stream.sv
// Buffered UART transmitter: sensor words enter a FIFO and leave as start / data
// (LSB first) / optional parity / stop frames, back to back while data is queued.
module uart_tx_stream
    import uart_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned CLK_FREQ   = 100_000_000,
    parameter int unsigned BAUD_RATE  = 115200,
    parameter parity_e     PARITY     = PAR_NONE,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [DATA_WIDTH-1:0]               data_from_sensor,
    input  logic                                valid_from_sensor,
    output logic                                ready_to_sensor,
    output logic                                tx_sig,
    output logic                                busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]     fifo_level
);

    localparam int unsigned PULSE_WIDTH = bit_cycles(CLK_FREQ, BAUD_RATE);
    localparam int unsigned TMR_W       = (PULSE_WIDTH < 2) ? 1 : $clog2(PULSE_WIDTH);
    localparam int unsigned CNT_W       = $clog2(DATA_WIDTH);
    localparam logic [TMR_W-1:0] TMR_LOAD  = TMR_W'(PULSE_WIDTH - 1);
    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(DATA_WIDTH - 1);
    localparam logic             LAST_STOP = 1'(STOP_BITS - 1);
    localparam logic             PAR_EN    = (PARITY != PAR_NONE);

    if (PULSE_WIDTH < 2) begin : g_chk_pulse
        $error("uart_tx_stream: CLK_FREQ / BAUD_RATE must be at least 2");
    end
    if (DATA_WIDTH < 5 || DATA_WIDTH > 9) begin : g_chk_width
        $error("uart_tx_stream: DATA_WIDTH must be in 5..9");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_chk_stop
        $error("uart_tx_stream: STOP_BITS must be 1 or 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_chk_depth
        $error("uart_tx_stream: FIFO_DEPTH must be a power of two >= 2");
    end

    tx_state_e             state_q, state_d;
    logic [TMR_W-1:0]      timer_q, timer_d;
    logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  par_q, par_d;
    logic                  stop_cnt_q, stop_cnt_d;
    logic                  tx_q, tx_d;
    logic                  push, pop, tick;
    logic                  fifo_full, fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_rdata;

    assign ready_to_sensor = !fifo_full;
    assign push            = valid_from_sensor && !fifo_full;
    assign tx_sig          = tx_q;
    assign busy            = (state_q != IDLE);
    assign tick            = (timer_q == '0);

    sync_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata (data_from_sensor),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    // The FIFO read data lands on the pop edge, so the shift register and parity
    // are captured from it at the end of the start bit rather than at the pop.
    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        par_d      = par_q;
        stop_cnt_d = stop_cnt_q;
        pop        = 1'b0;

        if (state_q != IDLE && !tick) begin
            timer_d = timer_q - 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = START;
                    timer_d = TMR_LOAD;
                end
            end
            START: begin
                if (tick) begin
                    state_d   = DATA;
                    timer_d   = TMR_LOAD;
                    bit_cnt_d = '0;
                    shift_d   = fifo_rdata;
                    par_d     = (PARITY == PAR_ODD) ? ~(^fifo_rdata) : ^fifo_rdata;
                end
            end
            DATA: begin
                if (tick) begin
                    timer_d = TMR_LOAD;
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d    = PAR_EN ? uart_pkg::PARITY : STOP;
                        stop_cnt_d = 1'b0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        shift_d   = shift_q >> 1;
                    end
                end
            end
            uart_pkg::PARITY: begin
                if (tick) begin
                    state_d    = STOP;
                    timer_d    = TMR_LOAD;
                    stop_cnt_d = 1'b0;
                end
            end
            STOP: begin
                if (tick) begin
                    timer_d = TMR_LOAD;
                    if (stop_cnt_q == LAST_STOP) begin
                        if (!fifo_empty) begin
                            pop     = 1'b1;
                            state_d = START;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        stop_cnt_d = stop_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        case (state_d)
            START:            tx_d = 1'b0;
            DATA:             tx_d = shift_d[0];
            uart_pkg::PARITY: tx_d = par_d;
            default:          tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            timer_q    <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            par_q      <= 1'b0;
            stop_cnt_q <= 1'b0;
            tx_q       <= 1'b1;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            stop_cnt_q <= stop_cnt_d;
            tx_q       <= tx_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_stream.sv
// Directed bench for uart_tx_stream at PULSE_WIDTH = 10 across several frame formats.
module tb_uart_tx_stream;
    import uart_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // a: 8N1 depth 4, e: 8E1, o: 8O1, s: 8N2, w: 5N1
    logic [7:0] d_a = '0, d_e = '0, d_o = '0, d_s = '0;
    logic [4:0] d_w = '0;
    logic       v_a = 1'b0, v_e = 1'b0, v_o = 1'b0, v_s = 1'b0, v_w = 1'b0;
    logic       rdy_a, rdy_e, rdy_o, rdy_s, rdy_w;
    logic       tx_a, tx_e, tx_o, tx_s, tx_w;
    logic       busy_a, busy_e, busy_o, busy_s, busy_w;
    logic [2:0] lvl_a, lvl_e, lvl_o, lvl_s, lvl_w;

    uart_tx_stream #(.DATA_WIDTH(8), .CLK_FREQ(100_000_000), .BAUD_RATE(10_000_000),
                     .PARITY(PAR_NONE), .STOP_BITS(1), .FIFO_DEPTH(4)) u_a (
        .clk(clk), .rst(rst), .data_from_sensor(d_a), .valid_from_sensor(v_a),
        .ready_to_sensor(rdy_a), .tx_sig(tx_a), .busy(busy_a), .fifo_level(lvl_a));

    uart_tx_stream #(.DATA_WIDTH(8), .CLK_FREQ(100_000_000), .BAUD_RATE(10_000_000),
                     .PARITY(PAR_EVEN), .STOP_BITS(1), .FIFO_DEPTH(4)) u_e (
        .clk(clk), .rst(rst), .data_from_sensor(d_e), .valid_from_sensor(v_e),
        .ready_to_sensor(rdy_e), .tx_sig(tx_e), .busy(busy_e), .fifo_level(lvl_e));

    uart_tx_stream #(.DATA_WIDTH(8), .CLK_FREQ(100_000_000), .BAUD_RATE(10_000_000),
                     .PARITY(PAR_ODD), .STOP_BITS(1), .FIFO_DEPTH(4)) u_o (
        .clk(clk), .rst(rst), .data_from_sensor(d_o), .valid_from_sensor(v_o),
        .ready_to_sensor(rdy_o), .tx_sig(tx_o), .busy(busy_o), .fifo_level(lvl_o));

    uart_tx_stream #(.DATA_WIDTH(8), .CLK_FREQ(100_000_000), .BAUD_RATE(10_000_000),
                     .PARITY(PAR_NONE), .STOP_BITS(2), .FIFO_DEPTH(4)) u_s (
        .clk(clk), .rst(rst), .data_from_sensor(d_s), .valid_from_sensor(v_s),
        .ready_to_sensor(rdy_s), .tx_sig(tx_s), .busy(busy_s), .fifo_level(lvl_s));

    uart_tx_stream #(.DATA_WIDTH(5), .CLK_FREQ(100_000_000), .BAUD_RATE(10_000_000),
                     .PARITY(PAR_NONE), .STOP_BITS(1), .FIFO_DEPTH(4)) u_w (
        .clk(clk), .rst(rst), .data_from_sensor(d_w), .valid_from_sensor(v_w),
        .ready_to_sensor(rdy_w), .tx_sig(tx_w), .busy(busy_w), .fifo_level(lvl_w));

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({tx_a, tx_e, tx_o, tx_s, tx_w} !== 5'b11111 ||
            {busy_a, busy_e, busy_o, busy_s, busy_w} !== 5'b00000 ||
            {rdy_a, rdy_e, rdy_o, rdy_s, rdy_w} !== 5'b11111 ||
            {lvl_a, lvl_e, lvl_o, lvl_s, lvl_w} !== 15'd0) begin
            n_fail++;
            $display("FAIL reset_state: tx=%b busy=%b rdy=%b lvl=%h, want tx=11111 busy=00000 rdy=11111 lvl=0",
                     {tx_a, tx_e, tx_o, tx_s, tx_w}, {busy_a, busy_e, busy_o, busy_s, busy_w},
                     {rdy_a, rdy_e, rdy_o, rdy_s, rdy_w}, {lvl_a, lvl_e, lvl_o, lvl_s, lvl_w});
        end
        rst = 1'b0;
    endtask

    task automatic test_8n1();
        logic [9:0] exp;
        exp = {1'b1, 8'hA5, 1'b0};
        @(negedge clk); d_a = 8'hA5; v_a = 1'b1;
        @(negedge clk); v_a = 1'b0;
        n_cmp++;
        if (lvl_a !== 3'd1 || tx_a !== 1'b1 || busy_a !== 1'b0) begin
            n_fail++;
            $display("FAIL 8n1_after_push: lvl=%0d tx=%b busy=%b, want lvl=1 tx=1 busy=0", lvl_a, tx_a, busy_a);
        end
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            n_cmp++;
            if (tx_a !== exp[k/10] || busy_a !== 1'b1) begin
                n_fail++;
                $display("FAIL 8n1_frame cyc=%0d: tx=%b busy=%b, want tx=%b busy=1", k, tx_a, busy_a, exp[k/10]);
            end
        end
        @(negedge clk);
        n_cmp++;
        if (tx_a !== 1'b1 || busy_a !== 1'b0 || lvl_a !== 3'd0) begin
            n_fail++;
            $display("FAIL 8n1_end: tx=%b busy=%b lvl=%0d, want tx=1 busy=0 lvl=0", tx_a, busy_a, lvl_a);
        end
    endtask

    task automatic test_parity();
        logic [7:0]  words [3] = '{8'h07, 8'h03, 8'h07};
        logic        pbits [3] = '{1'b1, 1'b0, 1'b0};
        logic [10:0] exp;
        logic        tx_v, busy_v;
        for (int t = 0; t < 3; t++) begin
            exp = {1'b1, pbits[t], words[t], 1'b0};
            @(negedge clk);
            if (t < 2) begin d_e = words[t]; v_e = 1'b1; end
            else       begin d_o = words[t]; v_o = 1'b1; end
            @(negedge clk); v_e = 1'b0; v_o = 1'b0;
            for (int k = 0; k < 111; k++) begin
                @(negedge clk);
                tx_v   = (t < 2) ? tx_e : tx_o;
                busy_v = (t < 2) ? busy_e : busy_o;
                n_cmp++;
                if (k < 110 && (tx_v !== exp[k/10] || busy_v !== 1'b1)) begin
                    n_fail++;
                    $display("FAIL parity_frame t=%0d cyc=%0d: tx=%b busy=%b, want tx=%b busy=1",
                             t, k, tx_v, busy_v, exp[k/10]);
                end else if (k == 110 && (tx_v !== 1'b1 || busy_v !== 1'b0)) begin
                    n_fail++;
                    $display("FAIL parity_end t=%0d: tx=%b busy=%b, want tx=1 busy=0", t, tx_v, busy_v);
                end
            end
        end
    endtask

    task automatic test_two_stop();
        logic [10:0] exp;
        exp = {2'b11, 8'h00, 1'b0};
        @(negedge clk); d_s = 8'h00; v_s = 1'b1;
        @(negedge clk); v_s = 1'b0;
        for (int k = 0; k < 111; k++) begin
            @(negedge clk);
            n_cmp++;
            if (k < 110 && (tx_s !== exp[k/10] || busy_s !== 1'b1)) begin
                n_fail++;
                $display("FAIL 8n2_frame cyc=%0d: tx=%b busy=%b, want tx=%b busy=1", k, tx_s, busy_s, exp[k/10]);
            end else if (k == 110 && (tx_s !== 1'b1 || busy_s !== 1'b0)) begin
                n_fail++;
                $display("FAIL 8n2_end: tx=%b busy=%b, want tx=1 busy=0", tx_s, busy_s);
            end
        end
    endtask

    task automatic test_width5();
        logic [6:0] exp;
        exp = {1'b1, 5'b10110, 1'b0};
        @(negedge clk); d_w = 5'b10110; v_w = 1'b1;
        @(negedge clk); v_w = 1'b0;
        for (int k = 0; k < 71; k++) begin
            @(negedge clk);
            n_cmp++;
            if (k < 70 && (tx_w !== exp[k/10] || busy_w !== 1'b1)) begin
                n_fail++;
                $display("FAIL 5n1_frame cyc=%0d: tx=%b busy=%b, want tx=%b busy=1", k, tx_w, busy_w, exp[k/10]);
            end else if (k == 70 && (tx_w !== 1'b1 || busy_w !== 1'b0)) begin
                n_fail++;
                $display("FAIL 5n1_end: tx=%b busy=%b, want tx=1 busy=0", tx_w, busy_w);
            end
        end
    endtask

    task automatic test_back_to_back();
        int unsigned word = 1;
        logic        pend = 1'b0;
        int          acc [6] = '{-1, -1, -1, -1, -1, -1};
        int          exp_acc [6] = '{0, 1, 2, 3, 4, 102};
        int          nacc = 0;
        int          j, k;
        logic [9:0]  exp;
        for (int c = 0; c <= 602; c++) begin
            @(negedge clk);
            if (c == 0) begin
                d_a = 8'd1; v_a = 1'b1;
            end else if (pend) begin
                word++;
                d_a = 8'(word);
                if (word > 6) v_a = 1'b0;
            end
            pend = v_a && rdy_a;
            if (pend && nacc < 6) begin acc[nacc] = c; nacc++; end
            if (c >= 2 && c <= 601) begin
                j = (c - 2) / 100;
                k = ((c - 2) % 100) / 10;
                exp = {1'b1, 8'(j + 1), 1'b0};
                n_cmp++;
                if (tx_a !== exp[k] || busy_a !== 1'b1) begin
                    n_fail++;
                    $display("FAIL b2b_line c=%0d: tx=%b busy=%b, want tx=%b busy=1", c, tx_a, busy_a, exp[k]);
                end
            end
            if (c == 5 || c == 101) begin
                n_cmp++;
                if (lvl_a !== 3'd4 || rdy_a !== 1'b0) begin
                    n_fail++;
                    $display("FAIL b2b_full c=%0d: lvl=%0d rdy=%b, want lvl=4 rdy=0", c, lvl_a, rdy_a);
                end
            end
            if (c == 102) begin
                n_cmp++;
                if (lvl_a !== 3'd3 || rdy_a !== 1'b1) begin
                    n_fail++;
                    $display("FAIL b2b_after_pop: lvl=%0d rdy=%b, want lvl=3 rdy=1", lvl_a, rdy_a);
                end
            end
            if (c == 103) begin
                n_cmp++;
                if (lvl_a !== 3'd4) begin
                    n_fail++;
                    $display("FAIL b2b_refill: lvl=%0d, want 4", lvl_a);
                end
            end
            if (c == 602) begin
                n_cmp++;
                if (tx_a !== 1'b1 || busy_a !== 1'b0 || lvl_a !== 3'd0) begin
                    n_fail++;
                    $display("FAIL b2b_end: tx=%b busy=%b lvl=%0d, want tx=1 busy=0 lvl=0", tx_a, busy_a, lvl_a);
                end
            end
        end
        for (int i = 0; i < 6; i++) begin
            n_cmp++;
            if (acc[i] !== exp_acc[i]) begin
                n_fail++;
                $display("FAIL b2b_accept word=%0d: cycle=%0d, want %0d", i + 1, acc[i], exp_acc[i]);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [9:0] exp;
        int         bad = 0;
        exp = {1'b1, 8'h3C, 1'b0};
        @(negedge clk); d_a = 8'h5A; v_a = 1'b1;
        @(negedge clk); d_a = 8'hC3;
        @(negedge clk); v_a = 1'b0;
        repeat (34) @(negedge clk);
        n_cmp++;
        if (tx_a !== 1'b0 || lvl_a !== 3'd1 || busy_a !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_mid_pre: tx=%b lvl=%0d busy=%b, want tx=0 lvl=1 busy=1", tx_a, lvl_a, busy_a);
        end
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (tx_a !== 1'b1 || busy_a !== 1'b0 || lvl_a !== 3'd0 || rdy_a !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_mid_state: tx=%b busy=%b lvl=%0d rdy=%b, want tx=1 busy=0 lvl=0 rdy=1",
                     tx_a, busy_a, lvl_a, rdy_a);
        end
        rst = 1'b0;
        for (int k = 0; k < 150; k++) begin
            @(negedge clk);
            if (tx_a !== 1'b1 || busy_a !== 1'b0) bad++;
        end
        n_cmp++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL rst_mid_quiet: %0d active cycles after reset, want 0", bad);
        end
        d_a = 8'h3C; v_a = 1'b1;
        @(negedge clk); v_a = 1'b0;
        for (int k = 0; k < 101; k++) begin
            @(negedge clk);
            n_cmp++;
            if (k < 100 && (tx_a !== exp[k/10] || busy_a !== 1'b1)) begin
                n_fail++;
                $display("FAIL rst_mid_frame cyc=%0d: tx=%b busy=%b, want tx=%b busy=1", k, tx_a, busy_a, exp[k/10]);
            end else if (k == 100 && (tx_a !== 1'b1 || busy_a !== 1'b0)) begin
                n_fail++;
                $display("FAIL rst_mid_end: tx=%b busy=%b, want tx=1 busy=0", tx_a, busy_a);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_8n1();
        test_parity();
        test_two_stop();
        test_width5();
        test_back_to_back();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
